// File: rtl/delay_cfg_sched.sv
// Round-robin delay-change scheduler in front of a variable delay line.
// Holds the output invalid while the line settles after reset or a delay change.
module delay_cfg_sched #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DELAY_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [N_REQ*DELAY_W-1:0]   req_delay_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o,
  input  logic                       data_i,
  output logic                       dly_data_o,
  output logic [DELAY_W-1:0]         dly_delay_o,
  input  logic                       dly_data_i,
  output logic                       data_o,
  output logic                       data_valid_o,
  output logic                       busy_o
);

  localparam int unsigned IdW = $clog2(N_REQ);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StSettle = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     gid_q, gid_d;

  logic               found;
  logic [IdW-1:0]     win;
  logic [DELAY_W-1:0] win_delay;
  int unsigned        idx;
  logic               hs;

  // Search starts at the round-robin pointer and wraps; first valid client wins.
  always_comb begin
    found     = 1'b0;
    win       = '0;
    win_delay = '0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(ptr_q) + i) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found     = 1'b1;
        win       = IdW'(idx);
        win_delay = req_delay_i[idx*DELAY_W +: DELAY_W];
      end
    end
  end

  assign hs = (state_q == StIdle) && found;

  always_comb begin
    req_ready_o = '0;
    if (hs) begin
      req_ready_o[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    case (state_q)
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (hs) begin
          gid_d = win;
          ptr_d = (32'(win) == N_REQ - 1) ? '0 : IdW'(32'(win) + 1);
          // An unchanged delay needs no settle window.
          if (win_delay != delay_q) begin
            delay_d = win_delay;
            cnt_d   = win_delay;
            state_d = StSettle;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StSettle;
      cnt_q   <= '0;
      delay_q <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
    end
  end

  assign dly_data_o   = data_i;
  assign data_o       = dly_data_i;
  assign dly_delay_o  = delay_q;
  assign grant_id_o   = gid_q;
  assign data_valid_o = (state_q == StIdle);
  assign busy_o       = (state_q == StSettle);

endmodule
